// File: rtl/apb_fsm_controller.sv
// APB sequencing FSM of the AHB-to-APB bridge.
// Takes the qualified AHB transfer plus its pipelined address/data/control and runs the APB
// setup and enable phases for up to three peripherals. Hreadyout stalls the AHB master while
// a buffered (pipelined) APB access is still pending.
//
// Ports
//   Hclk_i        bridge clock, rising edge
//   Hresetin_i    asynchronous active-high reset
//   valid_i       current AHB address phase is a bridge transfer
//   Hwrite_i      write flag of the current address phase
//   Hwritereg_i   Hwrite_i delayed one cycle
//   Haddr_i       current address; Haddr1_i / Haddr2_i are its 1- and 2-cycle delays
//   Hwdata_i      current write data; Hwdata1_i is its 1-cycle delay
//   tempselx_i    one-hot peripheral decode of Haddr_i
//   Pselx_o, Penable_o, Pwrite_o, Paddr_o, Pwdata_o   registered APB outputs
//   Hreadyout_o   1 = bridge accepts the next AHB phase
module apb_fsm_controller (
    input  logic        Hclk_i,
    input  logic        Hresetin_i,
    input  logic        valid_i,
    input  logic        Hwrite_i,
    input  logic        Hwritereg_i,
    input  logic [31:0] Haddr_i,
    input  logic [31:0] Haddr1_i,
    input  logic [31:0] Haddr2_i,
    input  logic [31:0] Hwdata_i,
    input  logic [31:0] Hwdata1_i,
    input  logic [2:0]  tempselx_i,
    output logic [2:0]  Pselx_o,
    output logic        Penable_o,
    output logic        Pwrite_o,
    output logic [31:0] Paddr_o,
    output logic [31:0] Pwdata_o,
    output logic        Hreadyout_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StRenable,
        StWwait,
        StWrite,
        StWritep,
        StWenable,
        StWenablep
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  sel1_q, sel2_q;
    logic [2:0]  pselx_q, pselx_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        hready_q, hready_d;

    always_comb begin
        // Every APB output holds unless a transition below loads it.
        state_d   = state_q;
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;

        unique case (state_q)
            // IDLE and the two non-pipelined enable states share one exit rule.
            StIdle, StRenable, StWenable: begin
                if (valid_i && !Hwrite_i) begin
                    state_d   = StRead;
                    paddr_d   = Haddr_i;
                    pselx_d   = tempselx_i;
                    pwrite_d  = 1'b0;
                    penable_d = 1'b0;
                    hready_d  = 1'b0;
                end else begin
                    state_d   = (valid_i && Hwrite_i) ? StWwait : StIdle;
                    pselx_d   = 3'b000;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                end
            end
            StRead: begin
                state_d   = StRenable;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            StWwait: begin
                // Write data arrives one cycle after the address, so the setup uses Haddr1.
                state_d   = valid_i ? StWritep : StWrite;
                paddr_d   = Haddr1_i;
                pwdata_d  = Hwdata_i;
                pselx_d   = sel1_q;
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                hready_d  = !valid_i;
            end
            StWrite: begin
                state_d   = valid_i ? StWenablep : StWenable;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            StWritep: begin
                state_d   = StWenablep;
                penable_d = 1'b1;
                hready_d  = 1'b0;
            end
            StWenablep: begin
                // Serve the transfer buffered while the previous write was in flight.
                paddr_d   = Haddr2_i;
                pselx_d   = sel2_q;
                penable_d = 1'b0;
                if (!Hwritereg_i) begin
                    state_d  = StRead;
                    pwrite_d = 1'b0;
                    hready_d = 1'b0;
                end else begin
                    state_d  = valid_i ? StWritep : StWrite;
                    pwdata_d = Hwdata1_i;
                    pwrite_d = 1'b1;
                    hready_d = !valid_i;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk_i or posedge Hresetin_i) begin
        if (Hresetin_i) begin
            state_q   <= StIdle;
            sel1_q    <= 3'b000;
            sel2_q    <= 3'b000;
            pselx_q   <= 3'b000;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 32'h0;
            pwdata_q  <= 32'h0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel1_q    <= tempselx_i;
            sel2_q    <= sel1_q;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    assign Pselx_o     = pselx_q;
    assign Penable_o   = penable_q;
    assign Pwrite_o    = pwrite_q;
    assign Paddr_o     = paddr_q;
    assign Pwdata_o    = pwdata_q;
    assign Hreadyout_o = hready_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller. Each cycle drives AHB-side inputs and pushes the
// expected registered APB outputs; they are popped and compared just after the next edge.
module tb_apb_fsm_controller;

    logic        Hclk, Hresetin;
    logic        valid, Hwrite, Hwritereg;
    logic [31:0] Haddr, Haddr1, Haddr2, Hwdata, Hwdata1;
    logic [2:0]  tempselx;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite, Hreadyout;
    logic [31:0] Paddr, Pwdata;

    typedef struct packed {
        logic [2:0]  pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hready;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    apb_fsm_controller dut (
        .Hclk_i      (Hclk),
        .Hresetin_i  (Hresetin),
        .valid_i     (valid),
        .Hwrite_i    (Hwrite),
        .Hwritereg_i (Hwritereg),
        .Haddr_i     (Haddr),
        .Haddr1_i    (Haddr1),
        .Haddr2_i    (Haddr2),
        .Hwdata_i    (Hwdata),
        .Hwdata1_i   (Hwdata1),
        .tempselx_i  (tempselx),
        .Pselx_o     (Pselx),
        .Penable_o   (Penable),
        .Pwrite_o    (Pwrite),
        .Paddr_o     (Paddr),
        .Pwdata_o    (Pwdata),
        .Hreadyout_o (Hreadyout)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Upstream AHB slave pipeline registers.
    always @(posedge Hclk or posedge Hresetin) begin
        if (Hresetin) begin
            Hwritereg <= 1'b0;
            Haddr1    <= 32'h0;
            Haddr2    <= 32'h0;
            Hwdata1   <= 32'h0;
        end else begin
            Hwritereg <= Hwrite;
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
        end
    end

    task automatic push(input logic [2:0] ps, input logic pe, input logic pw,
                        input logic [31:0] pa, input logic [31:0] pd, input logic hr,
                        input string tag);
        exp_t e;
        e.pselx = ps; e.penable = pe; e.pwrite = pw;
        e.paddr = pa; e.pwdata = pd; e.hready = hr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (Pselx === e.pselx) else begin
            n_fail++; $error("FAIL %s Pselx got %b want %b", t, Pselx, e.pselx);
        end
        n_tests++;
        assert (Penable === e.penable) else begin
            n_fail++; $error("FAIL %s Penable got %b want %b", t, Penable, e.penable);
        end
        n_tests++;
        assert (Pwrite === e.pwrite) else begin
            n_fail++; $error("FAIL %s Pwrite got %b want %b", t, Pwrite, e.pwrite);
        end
        n_tests++;
        assert (Paddr === e.paddr) else begin
            n_fail++; $error("FAIL %s Paddr got %h want %h", t, Paddr, e.paddr);
        end
        n_tests++;
        assert (Pwdata === e.pwdata) else begin
            n_fail++; $error("FAIL %s Pwdata got %h want %h", t, Pwdata, e.pwdata);
        end
        n_tests++;
        assert (Hreadyout === e.hready) else begin
            n_fail++; $error("FAIL %s Hreadyout got %b want %b", t, Hreadyout, e.hready);
        end
    endtask

    // One cycle: drive inputs at negedge, expect outputs after the following posedge.
    task automatic cyc(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sel,
                       input logic [2:0] ps, input logic pe, input logic pw,
                       input logic [31:0] pa, input logic [31:0] pd, input logic hr,
                       input string tag);
        @(negedge Hclk);
        valid = v; Hwrite = w; Haddr = a; Hwdata = d; tempselx = sel;
        push(ps, pe, pw, pa, pd, hr, tag);
        @(posedge Hclk);
        #1;
        check_pop();
    endtask

    localparam logic [31:0] RdA  = 32'h8000_0010;
    localparam logic [31:0] WrA  = 32'h8400_0004;
    localparam logic [31:0] WrD  = 32'hDEAD_BEEF;
    localparam logic [31:0] BbA0 = 32'h8800_0000;
    localparam logic [31:0] BbA1 = 32'h8800_0004;
    localparam logic [31:0] XwA  = 32'h8000_0000;
    localparam logic [31:0] XwD  = 32'h0000_00AA;
    localparam logic [31:0] XrA  = 32'h8400_0008;
    localparam logic [31:0] ZwA  = 32'h8000_0004;
    localparam logic [31:0] ZwD  = 32'h1234_5678;
    localparam logic [31:0] QrA  = 32'h8000_0020;

    initial begin
        Hresetin = 1'b1;
        valid = 1'b0; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0; tempselx = 3'b000;

        @(posedge Hclk);
        #1;
        push(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "reset");
        check_pop();
        @(negedge Hclk);
        Hresetin = 1'b0;

        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 32'h0, 32'h0, 1, "idle_hold");

        // Single read
        cyc(1, 0, RdA, 0, 3'b001, 3'b001, 0, 0, RdA, 32'h0, 0, "rd_setup");
        cyc(0, 0, 0, 0, 3'b000, 3'b001, 1, 0, RdA, 32'h0, 1, "rd_enable");
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, RdA, 32'h0, 1, "rd_idle");

        // Single write
        cyc(1, 1, WrA, 0, 3'b010, 3'b000, 0, 0, RdA, 32'h0, 1, "wr_wwait");
        cyc(0, 0, 0, WrD, 3'b000, 3'b010, 0, 1, WrA, WrD, 1, "wr_setup");
        cyc(0, 0, 0, 0, 3'b000, 3'b010, 1, 1, WrA, WrD, 1, "wr_enable");
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 1, WrA, WrD, 1, "wr_idle");

        // Back-to-back writes; Hwrite held high while the master is stalled
        cyc(1, 1, BbA0, 0, 3'b100, 3'b000, 0, 1, WrA, WrD, 1, "bb_wwait");
        cyc(1, 1, BbA1, 1, 3'b100, 3'b100, 0, 1, BbA0, 32'h1, 0, "bb_writep");
        cyc(0, 1, BbA1, 2, 3'b000, 3'b100, 1, 1, BbA0, 32'h1, 0, "bb_wenablep");
        cyc(0, 0, 0, 0, 3'b000, 3'b100, 0, 1, BbA1, 32'h2, 1, "bb_write2");
        cyc(0, 0, 0, 0, 3'b000, 3'b100, 1, 1, BbA1, 32'h2, 1, "bb_wenable2");
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 1, BbA1, 32'h2, 1, "bb_idle");

        // Write followed by read
        cyc(1, 1, XwA, 0, 3'b001, 3'b000, 0, 1, BbA1, 32'h2, 1, "wr_rd_wwait");
        cyc(1, 0, XrA, XwD, 3'b010, 3'b001, 0, 1, XwA, XwD, 0, "wr_rd_writep");
        cyc(0, 0, XrA, 0, 3'b000, 3'b001, 1, 1, XwA, XwD, 0, "wr_rd_wenablep");
        cyc(0, 0, 0, 0, 3'b000, 3'b010, 0, 0, XrA, XwD, 0, "wr_rd_rsetup");
        cyc(0, 0, 0, 0, 3'b000, 3'b010, 1, 0, XrA, XwD, 1, "wr_rd_renable");
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, XrA, XwD, 1, "wr_rd_idle");

        // Asynchronous reset in the middle of a write enable
        cyc(1, 1, ZwA, 0, 3'b001, 3'b000, 0, 0, XrA, XwD, 1, "rst_wwait");
        cyc(0, 0, 0, ZwD, 3'b000, 3'b001, 0, 1, ZwA, ZwD, 1, "rst_setup");
        cyc(0, 0, 0, 0, 3'b000, 3'b001, 1, 1, ZwA, ZwD, 1, "rst_enable");
        #1;
        Hresetin = 1'b1;
        #1;
        push(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "async_reset");
        check_pop();
        #1;
        Hresetin = 1'b0;

        // Resume from IDLE
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 32'h0, 32'h0, 1, "post_rst_idle");
        cyc(1, 0, QrA, 0, 3'b001, 3'b001, 0, 0, QrA, 32'h0, 0, "post_rst_rsetup");
        cyc(0, 0, 0, 0, 3'b000, 3'b001, 1, 0, QrA, 32'h0, 1, "post_rst_renable");
        cyc(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, QrA, 32'h0, 1, "post_rst_idle2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

Downstream stage of the AHB slave interface in the AHB-to-APB bridge. Consumes the qualified transfer (`valid`), the pipelined address, data and control, and the decoded peripheral select. Drives the APB setup and enable phases to up to three peripherals. Returns `Hreadyout` to stall the AHB master while an APB access completes.

## Interface
- No parameters. Widths are fixed at 32-bit address/data and 3 peripheral selects.
- `Hclk` in 1: bridge clock; all state changes on its rising edge.
- `Hresetin` in 1: asynchronous, active-high reset.
- `valid` in 1: current AHB address phase is a NONSEQ/SEQ transfer to the bridge with `Hreadyin` high.
- `Hwrite` in 1: write flag of the current address phase.
- `Hwritereg` in 1: `Hwrite` delayed one `Hclk`.
- `Haddr` in 32: current address-phase address.
- `Haddr1` in 32: `Haddr` delayed one `Hclk`.
- `Haddr2` in 32: `Haddr1` delayed one `Hclk`.
- `Hwdata` in 32: current data-phase write data.
- `Hwdata1` in 32: `Hwdata` delayed one `Hclk`.
- `tempselx` in 3: one-hot decode of `Haddr` (001/010/100, 000 = none).
- `Pselx` out 3: APB select, one-hot or zero.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction, 1 = write.
- `Paddr` out 32: APB address.
- `Pwdata` out 32: APB write data.
- `Hreadyout` out 1: 1 = bridge accepts the next AHB phase.

## Operation
- All outputs are registered from the next-state decision. There are no combinational input-to-output paths.
- Internal registers:
  - `sel1`, which is `tempselx` delayed one cycle.
  - `sel2`, which is `sel1` delayed one cycle.
  - `state`, which is 3 bits.
- Reset values: `state`=IDLE, `Pselx`=000, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `Hreadyout`=1, `sel1`=`sel2`=000.
- States: IDLE, READ, RENABLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP.
- IDLE:
  - `valid&~Hwrite` → READ. Load `Paddr`←`Haddr`, `Pselx`←`tempselx`, `Pwrite`←0, `Penable`←0, `Hreadyout`←0.
  - `valid&Hwrite` → WWAIT. Set `Pselx`←0, `Penable`←0, `Hreadyout`←1.
  - Otherwise stay in IDLE with `Pselx`=0, `Penable`=0, `Hreadyout`=1.
- READ → RENABLE unconditionally. Set `Penable`←1, `Hreadyout`←1.
- WWAIT:
  - `valid` → WRITEP.
  - Otherwise → WRITE.
  - In both cases load `Paddr`←`Haddr1`, `Pwdata`←`Hwdata`, `Pselx`←`sel1`, `Pwrite`←1, `Penable`←0.
  - `Hreadyout`←0 on entry to WRITEP, 1 on entry to WRITE.
- WRITE:
  - `valid` → WENABLEP.
  - Otherwise → WENABLE.
  - Set `Penable`←1, `Hreadyout`←1.
- WRITEP → WENABLEP unconditionally. Set `Penable`←1, `Hreadyout`←0.
- RENABLE and WENABLE share one exit rule, which ends the APB access:
  - `valid&~Hwrite` → READ, with the same loads as IDLE→READ.
  - `valid&Hwrite` → WWAIT.
  - Otherwise → IDLE.
  - On the WWAIT and IDLE exits: `Pselx`←0, `Penable`←0, `Hreadyout`←1.
- WENABLEP serves the buffered (pipelined) transfer:
  - `~Hwritereg` → READ. Load `Paddr`←`Haddr2`, `Pselx`←`sel2`, `Pwrite`←0, `Hreadyout`←0.
  - `Hwritereg&valid` → WRITEP, with `Hreadyout`←0.
  - `Hwritereg&~valid` → WRITE, with `Hreadyout`←1.
  - Both write exits load `Paddr`←`Haddr2`, `Pwdata`←`Hwdata1`, `Pselx`←`sel2`, `Pwrite`←1.
  - All exits set `Penable`←0.
- `Pwdata` holds its value in every state that does not load it. `Paddr` and `Pwrite` likewise hold outside their load points.
- `Pselx` is never non-zero with more than one bit set. It may be 000 during an access when the decode was 000; the access still sequences normally.

## Timing
- Read: the setup phase (`Pselx`≠0, `Penable`=0) starts 1 cycle after the `valid` address phase. Enable follows in the next cycle.
- Read `Hreadyout`: low during the setup cycle, high in the enable cycle. Read data is sampled by the AHB side in the enable cycle.
- Write: setup starts 2 cycles after the address phase, because data arrives one cycle late. Enable follows in the next cycle.
- Every APB access is exactly 2 cycles (setup, then enable). There are no APB wait states; `Pready` is not used.
- Back-to-back writes: WENABLEP→WRITEP→WENABLEP repeats, giving one APB write per 2 cycles. `Hreadyout` toggles accordingly.
- Reset asserted in any state forces all reset values immediately, without waiting for a clock edge. Any in-flight APB access is abandoned with `Pselx` and `Penable` dropping to 0.
- The first state transition after reset deassertion occurs on the first `Hclk` edge that samples `Hresetin`=0.

## Test plan
- Idle hold: reset, then 10 cycles with `valid`=0 → `state` stays IDLE. `Pselx`=000, `Penable`=0, `Hreadyout`=1 throughout.
- Single read to 0x8000_0010 with `tempselx`=001 → next cycle `Paddr`=0x8000_0010, `Pselx`=001, `Pwrite`=0, `Penable`=0, `Hreadyout`=0. The cycle after: `Penable`=1, `Hreadyout`=1. Then IDLE.
- Single write to 0x8400_0004 with data 0xDEAD_BEEF, `tempselx`=010 → WWAIT, then `Paddr`=0x8400_0004, `Pwdata`=0xDEAD_BEEF, `Pselx`=010, `Pwrite`=1. The next cycle has `Penable`=1.
- Back-to-back writes to 0x8800_0000 and 0x8800_0004 (data 0x1, then 0x2) → two APB writes in order, each with a correct address/data pair. `Hreadyout`=0 during WRITEP.
- Write to 0x8000_0000 followed by a read from 0x8400_0008 → the APB write completes first. Then a read setup with `Paddr`=0x8400_0008, `Pwrite`=0.
- Asynchronous reset pulse mid-enable of a write → `Pselx`, `Penable` and `Pwdata` read 0, and `Hreadyout` reads 1, before the next `Hclk` edge. The block resumes from IDLE afterwards.
